ex_exec_unit: RTL and testbench
===============================

# ex_exec_unit

Execute-stage datapath core of the 5-stage MIPS pipeline. It combines three functions: a 32-bit ALU, a branch-condition evaluator and a data-memory access port to the bus bridge. The ALU and branch outputs are combinational and feed the EX/MEM pipeline register. The memory port issues bus requests in the EX cycle and registers the returned read word for the MEM stage.

## Interface
- No parameters.
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- `clk` in 1 — clock; all state updates on the rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `a` in 32 — ALU operand A (forwarded rs value).
- `b` in 32 — ALU operand B (forwarded rt value or extended immediate).
- `aluop` in 4 — ALU function select.
- `sa` in 5 — shift amount taken from the instruction.
- `alu_c` out 32 — ALU result.
- `alu_sum` out 32 — always `a+b` (mod 2^32); used as the memory address.
- `alu_zero` out 1 — high when `alu_c==0`.
- `br_rd1`, `br_rd2` in 32 — forwarded rs and rt values for the branch compare.
- `branch_type` in 3 — branch condition select.
- `branch_avail` out 1 — high when the branch is taken.
- `mem_write` in 1 — store request.
- `is_byte`, `is_half` in 1 — access size; neither set means word; `is_byte` wins if both are set.
- `wdata_in` in 32 — store data (forwarded rt value).
- `bus_addr` out 32 — word-aligned address, `{alu_sum[31:2],2'b00}`.
- `bus_we` out 1 — equals `mem_write`.
- `bus_be` out 4 — byte enables.
- `bus_wdata` out 32 — lane-replicated store data.
- `bus_rdata` in 32 — combinational read word from the bridge.
- `dm_out` out 32 — registered read word.

## Operation
- ALU, selected by `aluop`:
  - 0: ADD.
  - 1: SUB (`a-b`).
  - 2: AND.
  - 3: OR.
  - 4: XOR.
  - 5: NOR.
  - 6: SLL (`b<<sa`).
  - 7: SRL (`b>>sa`).
  - 8: SRA (`b>>>sa`).
  - 9: SLLV (`b<<a[4:0]`).
  - 10: SRLV.
  - 11: SRAV.
  - 12: LUI (`{b[15:0],16'h0}`).
  - 13: SLT (signed, true compare, `{31'b0,lt}`; not overflow-prone).
  - 14: SLTU (unsigned).
  - 15: pass B.
  - All arithmetic wraps; no overflow trap or flag.
- Branch condition, selected by `branch_type` (signed 32-bit compares):
  - 0: never taken.
  - 1: BEQ, `rd1==rd2`.
  - 2: BNE.
  - 3: BLEZ, `rd1<=0`.
  - 4: BGTZ, `rd1>0`.
  - 5: BLTZ, `rd1<0`.
  - 6: BGEZ, `rd1>=0`.
  - 7: always taken.
- Memory access uses `off=alu_sum[1:0]`:
  - Byte: `bus_be = 4'b0001<<off`; `bus_wdata = {4{wdata_in[7:0]}}`.
  - Half: `bus_be = off[1] ? 4'b1100 : 4'b0011`; `bus_wdata = {2{wdata_in[15:0]}}`; `off[0]` ignored.
  - Word: `bus_be = 4'b1111`; `bus_wdata = wdata_in`; `off` ignored.
  - Misaligned accesses are silently aligned; no exception is raised.
  - `bus_be` and `bus_wdata` are driven regardless of `mem_write`. The bridge ignores them when `bus_we=0`.
- `dm_out` captures the full 32-bit `bus_rdata` every cycle. Lane selection and sign/zero extension are performed downstream in MEM.

## Timing
- ALU, branch and bus-request outputs are purely combinational: zero-cycle latency from their inputs.
- A store commits at the bridge on the rising edge that ends the EX cycle.
- Loads: the address is driven in cycle N and `dm_out` holds the read word in cycle N+1, i.e. one-cycle latency.
- `dm_out` updates every cycle, with no enable. A stall or flush is handled by the surrounding pipeline ignoring the value.
- Reset: `rst=0` clears `dm_out` to 0 asynchronously. Combinational outputs follow their inputs during reset.
- Reset asserted mid-load forces `dm_out=0` until the first edge after release.
- Store and load in the same cycle cannot occur. If the bridge returns data on a store cycle, it is still captured in `dm_out`.

## Test plan
- ALU sweep:
  - SUB `a=5,b=7` → `alu_c=0xFFFFFFFE`, `alu_zero=0`.
  - SLT `a=0x80000000,b=1` → `alu_c=1`.
  - SLTU same operands → `alu_c=0`.
  - SRA `b=0x80000000, sa=4` → `alu_c=0xF8000000`.
  - LUI `b=0x1234` → `alu_c=0x12340000`.
- Branches:
  - BEQ with 3/3 → 1; BNE with 3/3 → 0.
  - BLEZ with `rd1=0` → 1; BGTZ with `rd1=0xFFFFFFFF` → 0.
  - Type 0 → 0; type 7 → 1.
- Byte store:
  - `a=0x100, b=3, is_byte=1, mem_write=1, wdata_in=0xAB` → `bus_addr=0x100`, `bus_be=4'b1000`, `bus_wdata=0xABABABAB`, `bus_we=1`.
- Half store at offset 2:
  - `wdata_in=0x1234` → `bus_be=4'b1100`, `bus_wdata=0x12341234`.
  - Offset 3 with half size → same enables (`off[0]` ignored).
- Load latency:
  - Drive `bus_rdata=0xDEADBEEF` in cycle N → `dm_out=0xDEADBEEF` after the edge ending cycle N, not before.
- Asynchronous reset:
  - With `dm_out` nonzero, pull `rst` low between edges → `dm_out=0` immediately.
  - Release `rst`; the first edge loads `bus_rdata`.

Source files
------------

// File: rtl/ex_exec_unit.sv
// Execute-stage datapath: 32-bit ALU, branch-condition evaluator and the
// data-memory request port to the bus bridge, with the read word registered for MEM.
module ex_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluop,
  input  logic [4:0]  sa,
  output logic [31:0] alu_c,
  output logic [31:0] alu_sum,
  output logic        alu_zero,
  input  logic [31:0] br_rd1,
  input  logic [31:0] br_rd2,
  input  logic [2:0]  branch_type,
  output logic        branch_avail,
  input  logic        mem_write,
  input  logic        is_byte,
  input  logic        is_half,
  input  logic [31:0] wdata_in,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic [31:0] dm_out
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL,
    OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_LUI, OP_SLT, OP_SLTU, OP_PASSB
  } aluop_e;

  typedef enum logic [2:0] {
    BR_NEVER, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ, BR_ALWAYS
  } brtype_e;

  logic [1:0] off;
  logic       slt_lt;
  logic       sltu_lt;

  assign alu_sum  = a + b;
  assign alu_zero = (alu_c == 32'h0);
  // Direct signed compare rather than sign-of-difference, so no overflow hazard.
  assign slt_lt   = $signed(a) < $signed(b);
  assign sltu_lt  = a < b;

  always_comb begin
    alu_c = 32'h0;
    case (aluop_e'(aluop))
      OP_ADD:   alu_c = alu_sum;
      OP_SUB:   alu_c = a - b;
      OP_AND:   alu_c = a & b;
      OP_OR:    alu_c = a | b;
      OP_XOR:   alu_c = a ^ b;
      OP_NOR:   alu_c = ~(a | b);
      OP_SLL:   alu_c = b << sa;
      OP_SRL:   alu_c = b >> sa;
      OP_SRA:   alu_c = $unsigned($signed(b) >>> sa);
      OP_SLLV:  alu_c = b << a[4:0];
      OP_SRLV:  alu_c = b >> a[4:0];
      OP_SRAV:  alu_c = $unsigned($signed(b) >>> a[4:0]);
      OP_LUI:   alu_c = {b[15:0], 16'h0};
      OP_SLT:   alu_c = {31'b0, slt_lt};
      OP_SLTU:  alu_c = {31'b0, sltu_lt};
      OP_PASSB: alu_c = b;
      default:  alu_c = 32'h0;
    endcase
  end

  always_comb begin
    branch_avail = 1'b0;
    case (brtype_e'(branch_type))
      BR_NEVER:  branch_avail = 1'b0;
      BR_EQ:     branch_avail = (br_rd1 == br_rd2);
      BR_NE:     branch_avail = (br_rd1 != br_rd2);
      BR_LEZ:    branch_avail = $signed(br_rd1) <= 32'sd0;
      BR_GTZ:    branch_avail = $signed(br_rd1) >  32'sd0;
      BR_LTZ:    branch_avail = br_rd1[31];
      BR_GEZ:    branch_avail = ~br_rd1[31];
      BR_ALWAYS: branch_avail = 1'b1;
      default:   branch_avail = 1'b0;
    endcase
  end

  // Misaligned accesses are folded into the nearest legal lane set.
  assign off      = alu_sum[1:0];
  assign bus_addr = {alu_sum[31:2], 2'b00};
  assign bus_we   = mem_write;

  always_comb begin
    bus_be    = 4'b1111;
    bus_wdata = wdata_in;
    if (is_byte) begin
      bus_be    = 4'b0001 << off;
      bus_wdata = {4{wdata_in[7:0]}};
    end else if (is_half) begin
      bus_be    = off[1] ? 4'b1100 : 4'b0011;
      bus_wdata = {2{wdata_in[15:0]}};
    end
  end

  // Full word captured unconditionally; MEM does lane select and extension.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dm_out <= 32'h0;
    else      dm_out <= bus_rdata;
  end

endmodule

// File: tb/tb_ex_exec_unit.sv
// Scoreboard bench for ex_exec_unit: expectations are queued with the stimulus
// and drained against the DUT outputs once they are valid.
module tb_ex_exec_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, br_rd1, br_rd2, wdata_in, bus_rdata;
  logic [3:0]  aluop;
  logic [4:0]  sa;
  logic [2:0]  branch_type;
  logic        mem_write, is_byte, is_half;
  logic [31:0] alu_c, alu_sum, bus_addr, bus_wdata, dm_out;
  logic        alu_zero, branch_avail, bus_we;
  logic [3:0]  bus_be;

  int n_chk  = 0;
  int n_fail = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  ex_exec_unit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .aluop(aluop), .sa(sa),
    .alu_c(alu_c), .alu_sum(alu_sum), .alu_zero(alu_zero),
    .br_rd1(br_rd1), .br_rd2(br_rd2), .branch_type(branch_type),
    .branch_avail(branch_avail), .mem_write(mem_write), .is_byte(is_byte),
    .is_half(is_half), .wdata_in(wdata_in), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .dm_out(dm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  // Pop every pending expectation and compare it with the named output.
  task automatic drain();
    string       t;
    logic [31:0] e, act;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      case (t)
        "alu_c":    act = alu_c;
        "alu_zero": act = {31'b0, alu_zero};
        "alu_sum":  act = alu_sum;
        "br":       act = {31'b0, branch_avail};
        "addr":     act = bus_addr;
        "we":       act = {31'b0, bus_we};
        "be":       act = {28'b0, bus_be};
        "wdata":    act = bus_wdata;
        "dm":       act = dm_out;
        default:    act = 32'hxxxxxxxx;
      endcase
      chk(t, act, e);
    end
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                     input logic [4:0] isa, input logic [31:0] exp);
    aluop = op; a = ia; b = ib; sa = isa;
    push("alu_c", exp);
    push("alu_zero", {31'b0, exp == 32'h0});
    push("alu_sum", ia + ib);
    #1 drain();
  endtask

  task automatic br(input logic [2:0] bt, input logic [31:0] r1, input logic [31:0] r2,
                    input logic exp);
    branch_type = bt; br_rd1 = r1; br_rd2 = r2;
    push("br", {31'b0, exp});
    #1 drain();
  endtask

  task automatic mem(input logic [31:0] ia, input logic [31:0] ib, input logic w,
                     input logic by, input logic hf, input logic [31:0] wd,
                     input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd);
    aluop = 4'd0; a = ia; b = ib; mem_write = w; is_byte = by; is_half = hf; wdata_in = wd;
    push("addr", e_addr);
    push("we", {31'b0, w});
    push("be", {28'b0, e_be});
    push("wdata", e_wd);
    #1 drain();
  endtask

  initial begin
    rst = 1'b0; a = 0; b = 0; aluop = 0; sa = 0; br_rd1 = 0; br_rd2 = 0;
    branch_type = 0; mem_write = 0; is_byte = 0; is_half = 0; wdata_in = 0;
    bus_rdata = 32'h11111111;
    #2 push("dm", 32'h0); drain();
    @(posedge clk); #1 push("dm", 32'h0); drain();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 push("dm", 32'h11111111); drain();

    alu(4'd0,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0);
    alu(4'd1,  32'd5,        32'd7,        5'd0,  32'hFFFFFFFE);
    alu(4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000);
    alu(4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0);
    alu(4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0);
    alu(4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F);
    alu(4'd6,  32'h0,        32'h1,        5'd31, 32'h80000000);
    alu(4'd7,  32'h0,        32'h80000000, 5'd31, 32'h1);
    alu(4'd8,  32'h0,        32'h80000000, 5'd4,  32'hF8000000);
    alu(4'd9,  32'h24,       32'h3,        5'd0,  32'h30);
    alu(4'd10, 32'h4,        32'hF0000000, 5'd9,  32'h0F000000);
    alu(4'd11, 32'h4,        32'hF0000000, 5'd9,  32'hFF000000);
    alu(4'd12, 32'h0,        32'hFFFF1234, 5'd0,  32'h12340000);
    alu(4'd13, 32'h80000000, 32'h1,        5'd0,  32'h1);
    alu(4'd14, 32'h80000000, 32'h1,        5'd0,  32'h0);
    alu(4'd13, 32'h7FFFFFFF, 32'h80000000, 5'd0,  32'h0);
    alu(4'd15, 32'h12,       32'hCAFEBABE, 5'd0,  32'hCAFEBABE);

    br(3'd1, 32'd3,        32'd3, 1'b1);
    br(3'd2, 32'd3,        32'd3, 1'b0);
    br(3'd3, 32'd0,        32'd0, 1'b1);
    br(3'd3, 32'h80000000, 32'd0, 1'b1);
    br(3'd4, 32'hFFFFFFFF, 32'd0, 1'b0);
    br(3'd4, 32'd1,        32'd0, 1'b1);
    br(3'd5, 32'hFFFFFFFF, 32'd0, 1'b1);
    br(3'd6, 32'd0,        32'd0, 1'b1);
    br(3'd0, 32'd5,        32'd5, 1'b0);
    br(3'd7, 32'd5,        32'd6, 1'b1);

    mem(32'h100, 32'd3, 1'b1, 1'b1, 1'b0, 32'h000000AB, 32'h100, 4'b1000, 32'hABABABAB);
    mem(32'h100, 32'd2, 1'b1, 1'b0, 1'b1, 32'hFFFF1234, 32'h100, 4'b1100, 32'h12341234);
    mem(32'h100, 32'd3, 1'b1, 1'b0, 1'b1, 32'h00001234, 32'h100, 4'b1100, 32'h12341234);
    mem(32'h200, 32'd1, 1'b1, 1'b0, 1'b1, 32'h00005678, 32'h200, 4'b0011, 32'h56785678);
    mem(32'h200, 32'd7, 1'b1, 1'b0, 1'b0, 32'h89ABCDEF, 32'h204, 4'b1111, 32'h89ABCDEF);
    mem(32'h300, 32'd2, 1'b0, 1'b1, 1'b1, 32'h000000C3, 32'h300, 4'b0100, 32'hC3C3C3C3);

    // Load latency: value must not appear before the capturing edge.
    @(negedge clk); bus_rdata = 32'hDEADBEEF;
    #1 push("dm", 32'h11111111); drain();
    @(posedge clk); #1 push("dm", 32'hDEADBEEF); drain();

    // Asynchronous reset between edges, held across an edge, then released.
    @(negedge clk); #2 rst = 1'b0;
    #1 push("dm", 32'h0); drain();
    bus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1 push("dm", 32'h0); drain();
    @(negedge clk); rst = 1'b1;
    #1 push("dm", 32'h0); drain();
    @(posedge clk); #1 push("dm", 32'hCAFEF00D); drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
